pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
Parametrised next-generation program counter for the KGP-RISC fetch stage.
- Registers the fetch PC and updates it every cycle from a 4-bit control code: sequential, pseudo-direct jump, register jump, PC-relative branch, call, call-register, return and trap.
- Adds a stall input, a configurable reset/trap vector, and a circular return-address stack (RAS) so that calls and returns resolve without a register read.
- Sits between the decode/branch-resolution logic and instruction memory.

Parameters:
XLEN, 32, PC and register width; legal values 32 or 64.
RESET_VECTOR, 0, value loaded into pc on reset (XLEN bits).
TRAP_VECTOR, 32'hFFFF_FFF0, target for trap, illegal control code, RAS underflow and (optionally) misaligned targets.
RAS_DEPTH, 4, number of RAS entries; power of two, 2..16.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold pc and RAS unchanged this cycle
pc_control  input  4  next-PC select code
jump_address  input  26  pseudo-direct jump field
branch_offset  input  16  signed word offset
reg_address  input  XLEN  register-sourced target
pc  output  XLEN  current fetch PC (registered)
pc_plus4  output  XLEN  pc+4, combinational from pc
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)
illegal_ctrl  output  1  one-cycle pulse after an undefined code is accepted
ras_underflow  output  1  one-cycle pulse after a return with the RAS empty
misalign_err  output  1  one-cycle pulse after a misaligned target is accepted; 0 unless the optional feature is compiled in

Behaviour:
- Reset: sampled only on the rising edge of clk while rst=1.
  - pc=RESET_VECTOR, ras_count=0, RAS pointer=0, all pulse outputs 0.
  - Reset overrides stall and pc_control; a reset mid-call-sequence discards all RAS contents.
- Stall: stall=1 with rst=0 holds pc, RAS contents, pointer and ras_count; all pulses go to 0 next cycle.
- Update: when not stalled, pc_control is sampled at the edge and the new pc is visible after that edge (1-cycle latency).
- pc_control codes (P = pc+4, all arithmetic modulo 2^XLEN):
  - 0000 SEQ: pc <= P.
  - 0001 JUMP: pc <= {pc[XLEN-1:28], jump_address, 2'b00}.
  - 0010 JREG: pc <= reg_address.
  - 0011 BRANCH: pc <= P + (sign_extend_XLEN(branch_offset) << 2); wraps silently.
  - 0100 CALL: JUMP target; push P.
  - 0101 CALLR: JREG target; push P.
  - 0110 RET:
    - RAS not empty: pc <= top entry; pop.
    - RAS empty: pc <= TRAP_VECTOR, ras_underflow pulse, pointer unchanged.
  - 0111 TRAP: pc <= TRAP_VECTOR; RAS untouched.
  - 1000-1111: pc <= TRAP_VECTOR, illegal_ctrl pulse; RAS untouched.
- RAS operation:
  - Circular buffer of RAS_DEPTH x XLEN; a push writes at the pointer then increments it, a pop decrements it then reads.
  - ras_count increments on push, saturating at RAS_DEPTH, and decrements on pop.
  - Push when full overwrites the oldest entry (pointer wraps, ras_count stays RAS_DEPTH); no error is flagged.
  - Pointer wrap-around at RAS_DEPTH-1 -> 0 and 0 -> RAS_DEPTH-1 is required.
- Pulses: illegal_ctrl, ras_underflow and misalign_err are each high for exactly the one cycle following the accepting edge; otherwise 0.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: for JREG, CALLR and RET, a target with bits [1:0] != 0 is replaced by TRAP_VECTOR and misalign_err pulses.
  - For CALLR, the push is suppressed.
  - For RET, the pop still occurs.
- Undefined: the target's bits [1:0] are forced to 00 and misalign_err is tied to 0.

Test Plan:
- Reset with XLEN=32 and RESET_VECTOR=0x100, then 3 cycles of SEQ -> pc = 0x100, 0x104, 0x108, 0x10C; ras_count=0.
- pc=0x1000, BRANCH with offset 0xFFFF -> pc=0x1000; then pc=0xFFFFFFFC, SEQ -> pc=0x00000000 (wrap).
- pc=0xA0000010, CALL with jump_address=0x0000040 -> pc=0xA0000100, ras_count=1; then RET -> pc=0xA0000014, ras_count=0.
- RAS_DEPTH=4: 5 CALLs from PCs 0x0,0x10,0x20,0x30,0x40 (each pushes PC+4) -> ras_count=4; then 4 RETs return 0x44,0x34,0x24,0x14; a 5th RET -> pc=TRAP_VECTOR, ras_underflow high for 1 cycle.
- pc_control=1010 -> pc=TRAP_VECTOR, illegal_ctrl pulses once; then stall=1 with CALL for 3 cycles -> pc and ras_count unchanged.
- JREG with reg_address=0x2002 -> with PC_ALIGN_CHECK_EN: pc=TRAP_VECTOR and misalign_err=1; without it: pc=0x2000 and misalign_err=0.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Fetch-stage next-PC unit with a circular return-address stack (RAS).
// Latency: pc, ras_count and the error pulses update one cycle after pc_control is sampled; pc_plus4 is combinational from pc.
// Backpressure: stall=1 freezes pc, RAS contents, pointer and ras_count; the error pulses read 0 in the following cycle.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset (overrides stall and pc_control)
//   stall           - hold all state this cycle
//   pc_control      - next-PC select code (SEQ/JUMP/JREG/BRANCH/CALL/CALLR/RET/TRAP, 1xxx illegal)
//   jump_address    - 26-bit pseudo-direct jump field
//   branch_offset   - signed word offset for BRANCH
//   reg_address     - register-sourced target for JREG/CALLR
//   pc, pc_plus4    - current fetch PC and PC+4
//   ras_count       - number of valid RAS entries
//   illegal_ctrl, ras_underflow, misalign_err - one-cycle error pulses
//
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, misaligned JREG/CALLR/RET targets
// are redirected to TRAP_VECTOR and flagged on misalign_err; otherwise their low two bits are
// cleared and misalign_err stays 0.
module pc_unit_ras #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'hFFFF_FFF0),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic [3:0]                       pc_control,
    input  logic [25:0]                      jump_address,
    input  logic [15:0]                      branch_offset,
    input  logic [XLEN-1:0]                  reg_address,
    output logic [XLEN-1:0]                  pc,
    output logic [XLEN-1:0]                  pc_plus4,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             illegal_ctrl,
    output logic                             ras_underflow,
    output logic                             misalign_err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [3:0] CTRL_SEQ    = 4'b0000;
    localparam logic [3:0] CTRL_JUMP   = 4'b0001;
    localparam logic [3:0] CTRL_JREG   = 4'b0010;
    localparam logic [3:0] CTRL_BRANCH = 4'b0011;
    localparam logic [3:0] CTRL_CALL   = 4'b0100;
    localparam logic [3:0] CTRL_CALLR  = 4'b0101;
    localparam logic [3:0] CTRL_RET    = 4'b0110;
    localparam logic [3:0] CTRL_TRAP   = 4'b0111;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic            ill_q, ill_d;
    logic            unf_q, unf_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] br_off;
    logic [PW-1:0]   ptr_m1;
    logic [XLEN-1:0] rtarget;
    logic            redirect;
    logic            push;
    logic            pop;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jump_tgt = {pc_q[XLEN-1:28], jump_address, 2'b00};
    assign br_off   = {{(XLEN-18){branch_offset[15]}}, branch_offset, 2'b00};
    // Pointer addresses the next free slot; the top of stack sits one below it.
    assign ptr_m1   = ptr_q - PW'(1);

    always_comb begin
        pc_d     = pc_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ras_d    = ras_q;
        ill_d    = 1'b0;
        unf_d    = 1'b0;
        mis_d    = 1'b0;
        rtarget  = reg_address;
        redirect = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;

        if (!stall) begin
            case (pc_control)
                CTRL_SEQ:    pc_d = pc_plus4;
                CTRL_JUMP:   pc_d = jump_tgt;
                CTRL_JREG:   redirect = 1'b1;
                CTRL_BRANCH: pc_d = pc_plus4 + br_off;
                CTRL_CALL: begin
                    pc_d = jump_tgt;
                    push = 1'b1;
                end
                CTRL_CALLR: begin
                    redirect = 1'b1;
                    push     = 1'b1;
                end
                CTRL_RET: begin
                    if (cnt_q == '0) begin
                        pc_d  = TRAP_VECTOR;
                        unf_d = 1'b1;
                    end else begin
                        redirect = 1'b1;
                        rtarget  = ras_q[ptr_m1];
                        pop      = 1'b1;
                    end
                end
                CTRL_TRAP:   pc_d = TRAP_VECTOR;
                default: begin
                    pc_d  = TRAP_VECTOR;
                    ill_d = 1'b1;
                end
            endcase

            // Indirect targets: trap on misalignment when checking is built in,
            // otherwise silently word-align. A trapped CALLR must not push.
            if (redirect) begin
                if (ALIGN_CHECK && (rtarget[1:0] != 2'b00)) begin
                    pc_d  = TRAP_VECTOR;
                    mis_d = 1'b1;
                    push  = 1'b0;
                end else begin
                    pc_d = {rtarget[XLEN-1:2], 2'b00};
                end
            end

            // A push on a full stack overwrites the oldest entry via pointer wrap.
            if (push) begin
                ras_d[ptr_q] = pc_plus4;
                ptr_d        = ptr_q + PW'(1);
                if (cnt_q != CW'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (pop) begin
                ptr_d = ptr_m1;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ill_q <= 1'b0;
            unf_q <= 1'b0;
            mis_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ill_q <= ill_d;
            unf_q <= unf_d;
            mis_q <= mis_d;
            ras_q <= ras_d;
        end
    end

    assign pc            = pc_q;
    assign ras_count     = cnt_q;
    assign illegal_ctrl  = ill_q;
    assign ras_underflow = unf_q;
    assign misalign_err  = mis_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam logic [31:0] TV    = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [3:0]  pc_control;
    logic [25:0] jump_address;
    logic [15:0] branch_offset;
    logic [31:0] reg_address;
    logic [31:0] pc, pc_plus4;
    logic [2:0]  ras_count;
    logic        illegal_ctrl, ras_underflow, misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural PC, RAS as a bounded LIFO queue (oldest at front).
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    bit          m_ill, m_unf, m_mis;

    pc_unit_ras #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_control(pc_control),
        .jump_address(jump_address), .branch_offset(branch_offset),
        .reg_address(reg_address), .pc(pc), .pc_plus4(pc_plus4),
        .ras_count(ras_count), .illegal_ctrl(illegal_ctrl),
        .ras_underflow(ras_underflow), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Indirect target handling in the model.
    function automatic logic [31:0] fix_target(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        if ((t % 4) != 0) begin
            m_mis = 1'b1;
            return TV;
        end
        return t;
`else
        return t & ~32'd3;
`endif
    endfunction

    function automatic void model_push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    endfunction

    // Drive one cycle of inputs, advance the model, then sample #1 after the edge.
    task automatic step(input bit r, input bit s, input logic [3:0] c,
                        input logic [25:0] ja, input logic [15:0] bo, input logic [31:0] ra);
        logic [31:0] p;
        rst = r; stall = s; pc_control = c;
        jump_address = ja; branch_offset = bo; reg_address = ra;
        m_ill = 0; m_unf = 0; m_mis = 0;
        if (r) begin
            m_pc = RV;
            m_ras.delete();
        end else if (!s) begin
            p = m_pc + 32'd4;
            case (c)
                4'd0: m_pc = p;
                4'd1: m_pc = {m_pc[31:28], ja, 2'b00};
                4'd2: m_pc = fix_target(ra);
                4'd3: m_pc = p + 32'($signed(bo)) * 32'd4;
                4'd4: begin m_pc = {m_pc[31:28], ja, 2'b00}; model_push(p); end
                4'd5: begin m_pc = fix_target(ra); if (!m_mis) model_push(p); end
                4'd6: begin
                    if (m_ras.size() == 0) begin m_pc = TV; m_unf = 1; end
                    else m_pc = fix_target(m_ras.pop_back());
                end
                4'd7: m_pc = TV;
                default: begin m_pc = TV; m_ill = 1; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 4'd4, 26'h5, 16'h0, 32'h0);
        n_checks++; if (pc !== 32'h100) begin n_errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
        n_checks++; if (ras_count !== 3'd0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", ras_count); end
        n_checks++; if ({illegal_ctrl, ras_underflow, misalign_err} !== 3'b000) begin n_errors++; $display("FAIL reset_pulses got %b exp 000", {illegal_ctrl, ras_underflow, misalign_err}); end
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 4'd0, 26'h0, 16'h0, 32'h0);
            n_checks++; if (pc !== 32'h100 + 32'(4 * i)) begin n_errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, 32'h100 + 32'(4 * i)); end
            n_checks++; if (pc_plus4 !== 32'h104 + 32'(4 * i)) begin n_errors++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, pc_plus4, 32'h104 + 32'(4 * i)); end
        end
        n_checks++; if (ras_count !== 3'd0) begin n_errors++; $display("FAIL seq_cnt got %0d exp 0", ras_count); end
    endtask

    task automatic test_branch_wrap();
        step(0, 0, 4'd2, 26'h0, 16'h0, 32'h1000);
        step(0, 0, 4'd3, 26'h0, 16'hFFFF, 32'h0);
        n_checks++; if (pc !== 32'h1000) begin n_errors++; $display("FAIL branch_back got %h exp %h", pc, 32'h1000); end
        step(0, 0, 4'd2, 26'h0, 16'h0, 32'hFFFF_FFFC);
        step(0, 0, 4'd0, 26'h0, 16'h0, 32'h0);
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL seq_wrap got %h exp 0", pc); end
    endtask

    task automatic test_call_ret();
        step(0, 0, 4'd2, 26'h0, 16'h0, 32'hA000_0010);
        step(0, 0, 4'd4, 26'h40, 16'h0, 32'h0);
        n_checks++; if (pc !== 32'hA000_0100) begin n_errors++; $display("FAIL call_pc got %h exp %h", pc, 32'hA000_0100); end
        n_checks++; if (ras_count !== 3'd1) begin n_errors++; $display("FAIL call_cnt got %0d exp 1", ras_count); end
        step(0, 0, 4'd6, 26'h0, 16'h0, 32'h0);
        n_checks++; if (pc !== 32'hA000_0014) begin n_errors++; $display("FAIL ret_pc got %h exp %h", pc, 32'hA000_0014); end
        n_checks++; if (ras_count !== 3'd0) begin n_errors++; $display("FAIL ret_cnt got %0d exp 0", ras_count); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h44; exp_ret[1] = 32'h34; exp_ret[2] = 32'h24; exp_ret[3] = 32'h14;
        step(0, 0, 4'd2, 26'h0, 16'h0, 32'h0);
        // Calls from 0x0,0x10,..,0x40, each landing 0x10 further on.
        for (int i = 0; i < 5; i++) step(0, 0, 4'd4, 26'(4 * (i + 1)), 16'h0, 32'h0);
        n_checks++; if (ras_count !== 3'd4) begin n_errors++; $display("FAIL ovf_cnt got %0d exp 4", ras_count); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'd6, 26'h0, 16'h0, 32'h0);
            n_checks++; if (pc !== exp_ret[i]) begin n_errors++; $display("FAIL ovf_ret[%0d] got %h exp %h", i, pc, exp_ret[i]); end
        end
        step(0, 0, 4'd6, 26'h0, 16'h0, 32'h0);
        n_checks++; if (pc !== TV) begin n_errors++; $display("FAIL unf_pc got %h exp %h", pc, TV); end
        n_checks++; if (ras_underflow !== 1'b1) begin n_errors++; $display("FAIL unf_pulse got %b exp 1", ras_underflow); end
        step(0, 0, 4'd0, 26'h0, 16'h0, 32'h0);
        n_checks++; if (ras_underflow !== 1'b0) begin n_errors++; $display("FAIL unf_clear got %b exp 0", ras_underflow); end
    endtask

    task automatic test_illegal_stall();
        step(0, 0, 4'b1010, 26'h0, 16'h0, 32'h0);
        n_checks++; if (pc !== TV) begin n_errors++; $display("FAIL ill_pc got %h exp %h", pc, TV); end
        n_checks++; if (illegal_ctrl !== 1'b1) begin n_errors++; $display("FAIL ill_pulse got %b exp 1", illegal_ctrl); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'd4, 26'h123, 16'h0, 32'h0);
            n_checks++; if (pc !== TV || ras_count !== 3'd0) begin n_errors++; $display("FAIL stall_hold[%0d] got pc %h cnt %0d exp pc %h cnt 0", i, pc, ras_count, TV); end
            n_checks++; if (illegal_ctrl !== 1'b0) begin n_errors++; $display("FAIL stall_ill[%0d] got %b exp 0", i, illegal_ctrl); end
        end
    endtask

    task automatic test_misalign();
        step(0, 0, 4'd2, 26'h0, 16'h0, 32'h2002);
`ifdef PC_ALIGN_CHECK_EN
        n_checks++; if (pc !== TV) begin n_errors++; $display("FAIL mis_pc got %h exp %h", pc, TV); end
        n_checks++; if (misalign_err !== 1'b1) begin n_errors++; $display("FAIL mis_pulse got %b exp 1", misalign_err); end
`else
        n_checks++; if (pc !== 32'h2000) begin n_errors++; $display("FAIL mis_pc got %h exp %h", pc, 32'h2000); end
        n_checks++; if (misalign_err !== 1'b0) begin n_errors++; $display("FAIL mis_pulse got %b exp 0", misalign_err); end
`endif
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [31:0] ra;
        for (int i = 0; i < 600; i++) begin
            c  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(4, 6)) : 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
            step($urandom_range(0, 60) == 0, $urandom_range(0, 7) == 0, c,
                 26'($urandom), 16'($urandom), ra);
            n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, pc, m_pc); end
            n_checks++; if (pc_plus4 !== m_pc + 32'd4) begin n_errors++; $display("FAIL rnd_pc4[%0d] got %h exp %h", i, pc_plus4, m_pc + 32'd4); end
            n_checks++; if (ras_count !== 3'(m_ras.size())) begin n_errors++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, ras_count, m_ras.size()); end
            n_checks++; if ({illegal_ctrl, ras_underflow, misalign_err} !== {m_ill, m_unf, m_mis}) begin n_errors++; $display("FAIL rnd_pulses[%0d] got %b exp %b", i, {illegal_ctrl, ras_underflow, misalign_err}, {m_ill, m_unf, m_mis}); end
        end
    endtask

    initial begin
        rst = 1; stall = 0; pc_control = 0;
        jump_address = 0; branch_offset = 0; reg_address = 0;
        test_reset();
        test_branch_wrap();
        test_call_ret();
        test_ras_overflow();
        test_illegal_stall();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
